// File: rtl/video_gen_pkg.sv
// video_gen_pkg: shared types and helpers for the raster video generator.
package video_gen_pkg;
  typedef logic [11:0] cnt_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_SLOT} fetch_state_t;
  function automatic int bytes_per_line(input int h_active);
    return h_active / 8;
  endfunction
endpackage

// File: rtl/video_gen_timing.sv
// video_timing: pixel divider, raster counters, sync, window flags and frame pulse.
module video_timing import video_gen_pkg::*; #(
  parameter int CLK_DIV  = 2,
  parameter int H_TOTAL  = 256,
  parameter int H_SYNC   = 16,
  parameter int H_START  = 64,
  parameter int H_ACTIVE = 128,
  parameter int V_TOTAL  = 312,
  parameter int V_SYNC   = 4,
  parameter int V_START  = 40,
  parameter int V_ACTIVE = 128
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic hs,
  output logic vs,
  output logic active,
  output logic line_active,
  output logic group_load,
  output logic frame_irq
);
  logic [7:0] div;
  logic       hwrap;
  cnt_t       hn, vn, hoff_n;
  assign tick        = div == 8'(CLK_DIV - 1);
  assign hwrap       = hcount == cnt_t'(H_TOTAL - 1);
  assign hn          = hwrap ? '0 : hcount + cnt_t'(1);
  assign vn          = !hwrap ? vcount : vcount == cnt_t'(V_TOTAL - 1) ? '0 : vcount + cnt_t'(1);
  assign hs          = hcount < cnt_t'(H_SYNC);
  assign vs          = vcount < cnt_t'(V_SYNC);
  assign line_active = vcount >= cnt_t'(V_START) && vcount < cnt_t'(V_START + V_ACTIVE);
  assign active      = line_active && hcount >= cnt_t'(H_START) && hcount < cnt_t'(H_START + H_ACTIVE);
  // Shifter reloads on the tick that moves hcount onto an 8-pixel group start.
  assign hoff_n      = hn - cnt_t'(H_START);
  assign group_load  = tick && line_active && hoff_n < cnt_t'(H_ACTIVE) && hoff_n[2:0] == 3'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div       <= '0;
      hcount    <= '0;
      vcount    <= '0;
      frame_irq <= 1'b0;
    end else begin
      div       <= tick ? '0 : div + 8'd1;
      frame_irq <= tick && hn == '0 && vn == '0;
      if (tick) begin
        hcount <= hn;
        vcount <= vn;
      end
    end
endmodule

// File: rtl/video_gen.sv
// video_gen: raster generator fetching bitmap bytes over req/ack and shifting pixels MSB first.
module video_gen import video_gen_pkg::*; #(
  parameter int          CLK_DIV   = 2,
  parameter int          H_TOTAL   = 256,
  parameter int          H_SYNC    = 16,
  parameter int          H_START   = 64,
  parameter int          H_ACTIVE  = 128,
  parameter int          V_TOTAL   = 312,
  parameter int          V_SYNC    = 4,
  parameter int          V_START   = 40,
  parameter int          V_ACTIVE  = 128,
  parameter logic [15:0] VRAM_BASE = 16'hF800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memAck,
  input  logic [7:0]  memData,
  output logic        videoSync,
  output logic        videoPixel,
  output logic        frameIrq,
  output logic        underrun
);
  localparam int BYTES_PER_LINE = bytes_per_line(H_ACTIVE);
  fetch_state_t state, state_n;
  cnt_t         hcount, vcount, hoff;
  logic         tick, hs, vs, active, line_active, load, fetch_go, stale;
  logic [7:0]   buffer, shreg;
  logic [15:0]  next_addr;
  video_timing #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START),
    .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START),
    .V_ACTIVE(V_ACTIVE)
  ) u_timing (
    .clk(clk), .rst(reset), .tick(tick), .hcount(hcount), .vcount(vcount),
    .hs(hs), .vs(vs), .active(active), .line_active(line_active),
    .group_load(load), .frame_irq(frameIrq)
  );
  // Each request fetches the byte for the group that starts 8 pixels later.
  assign hoff      = hcount - cnt_t'(H_START - 8);
  assign fetch_go  = state == IDLE && enable && line_active && hoff < cnt_t'(H_ACTIVE) && hoff[2:0] == 3'd0;
  assign next_addr = VRAM_BASE + 16'((32'(vcount) - 32'(V_START)) * BYTES_PER_LINE) + 16'(hoff >> 3);
  assign memReq    = state == REQ;
  // An ack arriving after its group was already loaded (stale) is completed and dropped.
  always_comb
    state_n = state == IDLE ? (fetch_go ? REQ : IDLE) :
              state == REQ  ? (memAck ? (stale ? IDLE : WAIT_SLOT) : REQ) :
              (load ? IDLE : WAIT_SLOT);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      stale      <= 1'b0;
      buffer     <= '0;
      shreg      <= '0;
      memAddr    <= '0;
      videoSync  <= 1'b0;
      videoPixel <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      stale      <= state == REQ && !memAck && (stale || load);
      videoSync  <= hs ^ vs;
      videoPixel <= enable && active && shreg[7];
      if (fetch_go) memAddr <= next_addr;
      if (state == REQ && memAck && !stale) buffer <= memData;
      if (load) shreg <= state == WAIT_SLOT ? buffer : '0;
      else if (tick) shreg <= {shreg[6:0], 1'b0};
      if (load && state == REQ) underrun <= 1'b1;
    end
endmodule
